// File: rtl/mfb_frame_stats.sv
`default_nettype none
// ============================================================================
// mfb_frame_stats
//   Passive MFB TX-bus monitor: counts frames, runts and oversize frames,
//   and optionally items (build with MFB_FRAME_STATS_ITEMS_EN defined).
//   Revision: 1.0
// ============================================================================
module mfb_frame_stats #(
    parameter int REGIONS        = 4,
    parameter int REGION_SIZE    = 8,
    parameter int BLOCK_SIZE     = 8,
    parameter int ITEM_WIDTH     = 8,
    parameter int FRAME_SIZE_MIN = 60,
    parameter int FRAME_SIZE_MAX = 512,
    parameter int LEN_WIDTH      = 16,
    parameter int CNT_WIDTH      = 32,
    localparam int SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int EOF_POS_W = (REGION_SIZE*BLOCK_SIZE > 1) ? $clog2(REGION_SIZE*BLOCK_SIZE) : 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [REGIONS*SOF_POS_W-1:0] RX_SOF_POS,
    input  logic [REGIONS*EOF_POS_W-1:0] RX_EOF_POS,
    input  logic [REGIONS-1:0]           RX_SOF,
    input  logic [REGIONS-1:0]           RX_EOF,
    input  logic                         RX_SRC_RDY,
    input  logic                         RX_DST_RDY,
    input  logic                         CLEAR,
    input  logic                         SAMPLE,
    output logic                         STAT_VLD,
    output logic [CNT_WIDTH-1:0]         FRAMES_CNT,
    output logic [CNT_WIDTH-1:0]         RUNT_CNT,
    output logic [CNT_WIDTH-1:0]         OVERSIZE_CNT,
    output logic [CNT_WIDTH-1:0]         ITEMS_CNT
);

    localparam int LW1    = LEN_WIDTH + 1;
    localparam int LW2    = LEN_WIDTH + 2;
    localparam int INC_W  = $clog2(REGIONS + 1);
    localparam int ISUM_W = LEN_WIDTH + INC_W;
    localparam int SUM_W  = ((CNT_WIDTH > ISUM_W) ? CNT_WIDTH : ISUM_W) + 1;

    localparam logic [LEN_WIDTH-1:0] LEN_SAT      = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_SAT      = '1;
    localparam logic [LEN_WIDTH-1:0] LEN_MIN      = LEN_WIDTH'(FRAME_SIZE_MIN);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX      = LEN_WIDTH'(FRAME_SIZE_MAX);
    localparam logic [LW1-1:0]       REGION_ITEMS = LW1'(REGION_SIZE * BLOCK_SIZE);

    generate
        if (ITEM_WIDTH < 1 || REGION_SIZE * BLOCK_SIZE > int'(LEN_SAT) ||
            FRAME_SIZE_MAX >= int'(LEN_SAT)) begin : g_bad_cfg
            $error("mfb_frame_stats: inconsistent length/size parameters");
        end
    endgenerate

    function automatic logic [LEN_WIDTH-1:0] len_add(input logic [LEN_WIDTH-1:0] a,
                                                     input logic [LW1-1:0]       b);
        logic [LW2-1:0] s;
        s = LW2'(a) + LW2'(b);
        return (s > LW2'(LEN_SAT)) ? LEN_SAT : s[LEN_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                      input logic                 clr,
                                                      input logic [ISUM_W-1:0]    inc);
        logic [SUM_W-1:0] s;
        s = (clr ? SUM_W'(0) : SUM_W'(cur)) + SUM_W'(inc);
        return (s > SUM_W'(CNT_SAT)) ? CNT_SAT : s[CNT_WIDTH-1:0];
    endfunction

    logic                 accept;
    logic                 in_frame_q, in_frame_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [INC_W-1:0]     frames_inc, runt_inc, over_inc;
    logic [CNT_WIDTH-1:0] frames_q, runt_q, over_q;
    logic [CNT_WIDTH-1:0] frames_out_q, runt_out_q, over_out_q;
    logic                 stat_vld_q;
`ifdef MFB_FRAME_STATS_ITEMS_EN
    logic [ISUM_W-1:0]    items_inc;
    logic [CNT_WIDTH-1:0] items_q, items_out_q;
`endif

    assign accept = RX_SRC_RDY & RX_DST_RDY;

    // Regions are walked in bus order; in_frame_d/len_d carry the chain state.
    always_comb begin
        logic [SOF_POS_W-1:0] sp;
        logic [EOF_POS_W-1:0] ep;
        logic [LW1-1:0]       head, tail, single;
        logic                 close;
        logic [LEN_WIDTH-1:0] clen;

        in_frame_d = in_frame_q;
        len_d      = len_q;
        frames_inc = '0;
        runt_inc   = '0;
        over_inc   = '0;
`ifdef MFB_FRAME_STATS_ITEMS_EN
        items_inc  = '0;
`endif
        sp     = '0;
        ep     = '0;
        head   = '0;
        tail   = '0;
        single = '0;
        close  = 1'b0;
        clen   = '0;

        for (int r = 0; r < REGIONS; r++) begin
            sp     = RX_SOF_POS[r*SOF_POS_W +: SOF_POS_W];
            ep     = RX_EOF_POS[r*EOF_POS_W +: EOF_POS_W];
            head   = REGION_ITEMS - LW1'(sp) * LW1'(BLOCK_SIZE);
            tail   = LW1'(ep) + LW1'(1);
            single = tail - LW1'(sp) * LW1'(BLOCK_SIZE);
            close  = 1'b0;
            clen   = '0;

            if (accept) begin
                if (RX_SOF[r] && RX_EOF[r] && !in_frame_d) begin
                    close = 1'b1;
                    clen  = len_add(LEN_WIDTH'(0), single);
                end else if (RX_EOF[r] && in_frame_d) begin
                    // EOF precedes any SOF in the same region while a frame is open
                    close      = 1'b1;
                    clen       = len_add(len_d, tail);
                    in_frame_d = RX_SOF[r];
                    len_d      = RX_SOF[r] ? len_add(LEN_WIDTH'(0), head) : LEN_WIDTH'(0);
                end else if (RX_SOF[r]) begin
                    in_frame_d = 1'b1;
                    len_d      = len_add(LEN_WIDTH'(0), head);
                end else if (in_frame_d) begin
                    len_d = len_add(len_d, REGION_ITEMS);
                end
            end

            if (close) begin
                frames_inc = frames_inc + INC_W'(1);
                if (clen < LEN_MIN) runt_inc = runt_inc + INC_W'(1);
                if (clen > LEN_MAX) over_inc = over_inc + INC_W'(1);
`ifdef MFB_FRAME_STATS_ITEMS_EN
                items_inc = items_inc + ISUM_W'(clen);
`endif
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            in_frame_q   <= 1'b0;
            len_q        <= '0;
            frames_q     <= '0;
            runt_q       <= '0;
            over_q       <= '0;
            frames_out_q <= '0;
            runt_out_q   <= '0;
            over_out_q   <= '0;
            stat_vld_q   <= 1'b0;
        end else begin
            in_frame_q <= in_frame_d;
            len_q      <= len_d;
            frames_q   <= cnt_next(frames_q, CLEAR, ISUM_W'(frames_inc));
            runt_q     <= cnt_next(runt_q,   CLEAR, ISUM_W'(runt_inc));
            over_q     <= cnt_next(over_q,   CLEAR, ISUM_W'(over_inc));
            stat_vld_q <= SAMPLE;
            if (SAMPLE) begin
                frames_out_q <= frames_q;
                runt_out_q   <= runt_q;
                over_out_q   <= over_q;
            end
        end
    end

`ifdef MFB_FRAME_STATS_ITEMS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            items_q     <= '0;
            items_out_q <= '0;
        end else begin
            items_q <= cnt_next(items_q, CLEAR, items_inc);
            if (SAMPLE) items_out_q <= items_q;
        end
    end
    assign ITEMS_CNT = items_out_q;
`else
    assign ITEMS_CNT = '0;
`endif

    assign STAT_VLD     = stat_vld_q;
    assign FRAMES_CNT   = frames_out_q;
    assign RUNT_CNT     = runt_out_q;
    assign OVERSIZE_CNT = over_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mfb_frame_stats.sv
`default_nettype none
// ============================================================================
// tb_mfb_frame_stats
//   Directed and randomized bench; the model tracks frames by absolute item
//   position within the accepted stream.
//   Revision: 1.0
// ============================================================================
module tb_mfb_frame_stats;

    localparam int REGIONS     = 4;
    localparam int REGION_SIZE = 8;
    localparam int BLOCK_SIZE  = 8;
    localparam int FMIN        = 60;
    localparam int FMAX        = 512;
    localparam int SW          = 3;
    localparam int EW          = 6;
    localparam int RITEMS      = 64;
    localparam int WITEMS      = 256;
    localparam longint LEN_SAT = 65535;
    localparam longint CNT_SAT = 64'h0000_0000_FFFF_FFFF;
`ifdef MFB_FRAME_STATS_ITEMS_EN
    localparam bit ITEMS_EN = 1'b1;
`else
    localparam bit ITEMS_EN = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [REGIONS*SW-1:0]   sof_pos;
    logic [REGIONS*EW-1:0]   eof_pos;
    logic [REGIONS-1:0]      sof, eof;
    logic                    src, dst, clear, sample;
    logic                    STAT_VLD;
    logic [31:0]             FRAMES_CNT, RUNT_CNT, OVERSIZE_CNT, ITEMS_CNT;

    mfb_frame_stats #(
        .REGIONS(REGIONS), .REGION_SIZE(REGION_SIZE), .BLOCK_SIZE(BLOCK_SIZE),
        .ITEM_WIDTH(8), .FRAME_SIZE_MIN(FMIN), .FRAME_SIZE_MAX(FMAX),
        .LEN_WIDTH(16), .CNT_WIDTH(32)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .RX_SOF_POS(sof_pos), .RX_EOF_POS(eof_pos),
        .RX_SOF(sof), .RX_EOF(eof),
        .RX_SRC_RDY(src), .RX_DST_RDY(dst),
        .CLEAR(clear), .SAMPLE(sample),
        .STAT_VLD(STAT_VLD), .FRAMES_CNT(FRAMES_CNT), .RUNT_CNT(RUNT_CNT),
        .OVERSIZE_CNT(OVERSIZE_CNT), .ITEMS_CNT(ITEMS_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bit     m_in;
    longint m_start, m_pos;
    longint live_f, live_r, live_o, live_i;
    longint exp_f, exp_r, exp_o, exp_i;
    bit     exp_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("stat_vld", {63'd0, STAT_VLD}, {63'd0, exp_v});
            chk("frames",   {32'd0, FRAMES_CNT},   exp_f);
            chk("runt",     {32'd0, RUNT_CNT},     exp_r);
            chk("oversize", {32'd0, OVERSIZE_CNT}, exp_o);
            chk("items",    {32'd0, ITEMS_CNT},    exp_i);
        end
    end

    function automatic longint satc(input longint v);
        return (v > CNT_SAT) ? CNT_SAT : v;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic cycle();
        longint inc_f = 0, inc_r = 0, inc_o = 0, inc_i = 0;
        longint len, base, sp, ep;
        bit     nv;
        longint nf, nr, no, ni, lf, lr, lo, li;
        nv = sample;
        nf = exp_f; nr = exp_r; no = exp_o; ni = exp_i;
        if (sample) begin
            nf = live_f; nr = live_r; no = live_o;
            ni = ITEMS_EN ? live_i : 0;
        end
        if (src && dst) begin
            for (int r = 0; r < REGIONS; r++) begin
                base = m_pos + r * RITEMS;
                sp   = longint'(sof_pos[r*SW +: SW]);
                ep   = longint'(eof_pos[r*EW +: EW]);
                len  = -1;
                if (sof[r] && eof[r] && !m_in) begin
                    len = ep - sp * BLOCK_SIZE + 1;
                end else begin
                    if (eof[r] && m_in) begin
                        len  = base + ep - m_start + 1;
                        m_in = 1'b0;
                    end
                    if (sof[r]) begin
                        m_in    = 1'b1;
                        m_start = base + sp * BLOCK_SIZE;
                    end
                end
                if (len >= 0) begin
                    if (len > LEN_SAT) len = LEN_SAT;
                    inc_f++;
                    if (len < FMIN) inc_r++;
                    if (len > FMAX) inc_o++;
                    inc_i += len;
                end
            end
            m_pos += WITEMS;
        end
        lf = satc((clear ? 0 : live_f) + inc_f);
        lr = satc((clear ? 0 : live_r) + inc_r);
        lo = satc((clear ? 0 : live_o) + inc_o);
        li = satc((clear ? 0 : live_i) + inc_i);
        @(posedge CLK);
        #1;
        exp_v = nv; exp_f = nf; exp_r = nr; exp_o = no; exp_i = ni;
        live_f = lf; live_r = lr; live_o = lo; live_i = li;
    endtask

    task automatic clr_in();
        sof = '0; eof = '0; sof_pos = '0; eof_pos = '0;
        src = 1'b0; dst = 1'b0; sample = 1'b0; clear = 1'b0;
    endtask

    task automatic set_reg(input int r, input bit s, input int sp, input bit e, input int ep);
        sof[r] = s;
        eof[r] = e;
        sof_pos[r*SW +: SW] = SW'(sp);
        eof_pos[r*EW +: EW] = EW'(ep);
    endtask

    task automatic word();
        src = 1'b1; dst = 1'b1;
        cycle();
        clr_in();
    endtask

    task automatic snap();
        sample = 1'b1; clear = 1'b1;
        cycle();
        clr_in();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        m_in = 1'b0; m_pos = 0; m_start = 0;
        live_f = 0; live_r = 0; live_o = 0; live_i = 0;
        exp_f = 0; exp_r = 0; exp_o = 0; exp_i = 0; exp_v = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic lit(input string name, input longint f, input longint r,
                       input longint o, input longint i);
        chk({name, "_vld"},      {63'd0, STAT_VLD},       64'd1);
        chk({name, "_frames"},   {32'd0, FRAMES_CNT},     f);
        chk({name, "_runt"},     {32'd0, RUNT_CNT},       r);
        chk({name, "_oversize"}, {32'd0, OVERSIZE_CNT},   o);
        chk({name, "_items"},    {32'd0, ITEMS_CNT},      ITEMS_EN ? i : 0);
    endtask

    initial begin
        clr_in();
        RESET = 1'b0;
        #2;
        do_reset();
        cmp_en = 1'b1;

        chk("rst_vld",    {63'd0, STAT_VLD},   64'd0);
        chk("rst_frames", {32'd0, FRAMES_CNT}, 64'd0);
        chk("rst_items",  {32'd0, ITEMS_CNT},  64'd0);

        // single 64-item frame
        set_reg(0, 1, 0, 1, 63); word(); snap();
        lit("t1", 1, 0, 0, 64);

        // 40-item runt in region 2
        set_reg(2, 1, 1, 1, 47); word(); snap();
        lit("t2", 1, 1, 0, 40);

        // 600-item frame over three accepted words, with a stalled word in between
        set_reg(0, 1, 0, 0, 0); word();
        word();
        set_reg(0, 0, 0, 1, 0); set_reg(2, 1, 2, 1, 30);
        src = 1'b1; dst = 1'b0; cycle(); clr_in();
        set_reg(1, 0, 0, 1, 23); word(); snap();
        lit("t3", 1, 0, 1, 600);

        // four frames in one word
        for (int r = 0; r < REGIONS; r++) set_reg(r, 1, 0, 1, 63);
        word(); snap();
        lit("t4", 4, 0, 0, 256);

        // read-and-clear with a frame closing in the same cycle
        for (int r = 0; r < REGIONS; r++) set_reg(r, 1, 0, 1, 63);
        word();
        set_reg(0, 1, 0, 1, 63); word();
        set_reg(0, 1, 0, 1, 63); sample = 1'b1; clear = 1'b1; word();
        lit("t5a", 5, 0, 0, 320);
        snap();
        lit("t5b", 1, 0, 0, 64);

        // reset mid-frame, trailing EOF ignored
        set_reg(0, 1, 0, 0, 0); word();
        do_reset();
        set_reg(0, 0, 0, 1, 63); word(); snap();
        lit("t6", 0, 0, 0, 0);

        // length accumulator saturation
        set_reg(0, 1, 0, 0, 0); word();
        repeat (300) word();
        set_reg(0, 0, 0, 1, 63); word(); snap();
        lit("t7", 1, 0, 1, 65535);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit g;
            int k, sp;
            g = m_in;
            src = ($urandom_range(0, 3) != 0);
            dst = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < REGIONS; r++) begin
                k = int'($urandom_range(0, 9));
                if (g) begin
                    if (k < 5) begin
                        // continuation region
                    end else if (k < 8) begin
                        set_reg(r, 0, 0, 1, int'($urandom_range(0, 63)));
                        g = 1'b0;
                    end else if (k == 8) begin
                        sp = int'($urandom_range(1, 7));
                        set_reg(r, 1, sp, 1, int'($urandom_range(0, sp * 8 - 1)));
                    end else begin
                        set_reg(r, 1, int'($urandom_range(0, 7)), 0, 0);
                    end
                end else begin
                    if (k < 3) begin
                        // idle region
                    end else if (k < 6) begin
                        set_reg(r, 1, int'($urandom_range(0, 7)), 0, 0);
                        g = 1'b1;
                    end else if (k < 9) begin
                        sp = int'($urandom_range(0, 7));
                        set_reg(r, 1, sp, 1, int'($urandom_range(sp * 8, 63)));
                    end else begin
                        set_reg(r, 0, 0, 1, int'($urandom_range(0, 63)));
                    end
                end
            end
            sample = ($urandom_range(0, 7) == 0);
            clear  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else cycle();
            clr_in();
        end

        snap();
        cycle();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
